// File: rtl/projectile_pool.sv
`default_nettype none
// ============================================================================
// projectile_pool : N-slot projectile allocator and per-frame mover
// Rev 1.0
// ============================================================================
module projectile_pool #(
  parameter int NUM_SLOTS = 4,
  parameter int DIR_UP    = 1,
  parameter int STEP      = 4,
  parameter int X_OFFSET  = 14,
  parameter int Y_LIMIT   = 470,
  parameter int COOLDOWN  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame,
  input  logic                      fire,
  input  logic [9:0]                origin_x,
  input  logic [9:0]                origin_y,
  input  logic [NUM_SLOTS-1:0]      hit,
  output logic [NUM_SLOTS-1:0]      active,
  output logic [10*NUM_SLOTS-1:0]   pos_x,
  output logic [10*NUM_SLOTS-1:0]   pos_y,
  output logic                      fire_ack,
  output logic                      full
);

  localparam int              CD_W     = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] C_CD_LOAD = CD_W'(COOLDOWN);
  localparam logic [9:0]      C_STEP    = 10'(STEP);
  localparam logic [10:0]     C_LIMIT   = 11'(Y_LIMIT);
  localparam logic [9:0]      C_XOFF    = 10'(X_OFFSET);

  logic [CD_W-1:0]      r_cd;
  logic                 r_ack;
  logic [NUM_SLOTS-1:0] w_sel;
  logic                 w_any_free;
  logic                 w_spawn;

  // Lowest-index idle slot, judged on the registered (pre-cycle) mask.
  always_comb begin
    w_sel      = '0;
    w_any_free = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!active[i] && !w_any_free) begin
        w_sel[i]   = 1'b1;
        w_any_free = 1'b1;
      end
    end
  end

  assign w_spawn = fire && (r_cd == '0) && w_any_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cd  <= '0;
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_spawn;
      if (w_spawn)
        r_cd <= C_CD_LOAD;
      else if (frame && (r_cd != '0))
        r_cd <= r_cd - CD_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    logic       r_act;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [9:0] w_next_y;
    logic       w_exit;

    if (DIR_UP != 0) begin : g_up
      assign w_exit   = (r_y < C_STEP);
      assign w_next_y = r_y - C_STEP;
    end else begin : g_down
      logic [10:0] w_sum;
      assign w_sum    = {1'b0, r_y} + {1'b0, C_STEP};
      assign w_exit   = (w_sum > C_LIMIT);
      assign w_next_y = r_y + C_STEP;
    end

    // A spawning slot was idle last cycle, so hit/frame cannot touch it here.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_act <= 1'b0;
        r_x   <= '0;
        r_y   <= '0;
      end else if (w_spawn && w_sel[i]) begin
        r_act <= 1'b1;
        r_x   <= origin_x + C_XOFF;
        r_y   <= origin_y;
      end else if (r_act) begin
        if (hit[i])
          r_act <= 1'b0;
        else if (frame) begin
          if (w_exit)
            r_act <= 1'b0;
          else
            r_y <= w_next_y;
        end
      end
    end

    assign active[i]          = r_act;
    assign pos_x[10*i +: 10]  = r_x;
    assign pos_y[10*i +: 10]  = r_y;
  end

  assign fire_ack = r_ack;
  assign full     = &active;

endmodule
`default_nettype wire

// File: tb/tb_projectile_pool.sv
`default_nettype none
// ============================================================================
// tb_projectile_pool : directed checks on up, cooldown and down configurations
// Rev 1.0
// ============================================================================
module tb_projectile_pool;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // a: up, no cooldown   b: up, cooldown 8   c: down, no cooldown
  logic       rst_n_a = 1'b0, frame_a = 1'b0, fire_a = 1'b0;
  logic [9:0] ox_a = '0, oy_a = '0;
  logic [3:0] hit_a = '0, active_a;
  logic [39:0] px_a, py_a;
  logic       ack_a, full_a;

  logic       rst_n_b = 1'b0, frame_b = 1'b0, fire_b = 1'b0;
  logic [9:0] ox_b = '0, oy_b = '0;
  logic [3:0] hit_b = '0, active_b;
  logic [39:0] px_b, py_b;
  logic       ack_b, full_b;

  logic       rst_n_c = 1'b0, frame_c = 1'b0, fire_c = 1'b0;
  logic [9:0] ox_c = '0, oy_c = '0;
  logic [3:0] hit_c = '0, active_c;
  logic [39:0] px_c, py_c;
  logic       ack_c, full_c;

  projectile_pool #(.NUM_SLOTS(4), .DIR_UP(1), .STEP(4), .X_OFFSET(14), .Y_LIMIT(470), .COOLDOWN(0)) u_a (
    .clk(clk), .rst_n(rst_n_a), .frame(frame_a), .fire(fire_a), .origin_x(ox_a), .origin_y(oy_a),
    .hit(hit_a), .active(active_a), .pos_x(px_a), .pos_y(py_a), .fire_ack(ack_a), .full(full_a));

  projectile_pool #(.NUM_SLOTS(4), .DIR_UP(1), .STEP(4), .X_OFFSET(14), .Y_LIMIT(470), .COOLDOWN(8)) u_b (
    .clk(clk), .rst_n(rst_n_b), .frame(frame_b), .fire(fire_b), .origin_x(ox_b), .origin_y(oy_b),
    .hit(hit_b), .active(active_b), .pos_x(px_b), .pos_y(py_b), .fire_ack(ack_b), .full(full_b));

  projectile_pool #(.NUM_SLOTS(4), .DIR_UP(0), .STEP(4), .X_OFFSET(14), .Y_LIMIT(470), .COOLDOWN(0)) u_c (
    .clk(clk), .rst_n(rst_n_c), .frame(frame_c), .fire(fire_c), .origin_x(ox_c), .origin_y(oy_c),
    .hit(hit_c), .active(active_c), .pos_x(px_c), .pos_y(py_c), .fire_ack(ack_c), .full(full_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    check("rst_active_a", active_a, 0);
    check("rst_px_a", px_a[31:0], 0);
    check("rst_py_a", py_a[31:0], 0);
    check("rst_ack_a", ack_a, 0);
    check("rst_full_a", full_a, 0);
    check("rst_active_c", active_c, 0);
    tick();
    rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
    tick();

    // Spawn
    fire_a = 1'b1; ox_a = 10'd100; oy_a = 10'd440;
    tick();
    fire_a = 1'b0;
    check("spawn_active", active_a, 4'b0001);
    check("spawn_px0", px_a[9:0], 114);
    check("spawn_py0", py_a[9:0], 440);
    check("spawn_ack", ack_a, 1);
    tick();
    check("spawn_ack_drop", ack_a, 0);

    // Retire via hit, then top-exit motion
    hit_a = 4'b0001;
    tick();
    hit_a = 4'b0000;
    check("hit_retire", active_a, 4'b0000);
    fire_a = 1'b1; oy_a = 10'd10;
    tick();
    fire_a = 1'b0;
    check("up_spawn_y", py_a[9:0], 10);
    frame_a = 1'b1;
    tick();
    check("up_y6", py_a[9:0], 6);
    tick();
    check("up_y2", py_a[9:0], 2);
    tick();
    frame_a = 1'b0;
    check("up_exit_active", active_a, 4'b0000);
    check("up_exit_hold", py_a[9:0], 2);

    // Allocation order and full
    fire_a = 1'b1; ox_a = 10'd50; oy_a = 10'd300;
    tick(); check("alloc1", active_a, 4'b0001); check("alloc1_ack", ack_a, 1);
    tick(); check("alloc2", active_a, 4'b0011); check("alloc2_ack", ack_a, 1);
    tick(); check("alloc3", active_a, 4'b0111); check("alloc3_ack", ack_a, 1);
    tick(); check("alloc4", active_a, 4'b1111); check("alloc4_ack", ack_a, 1);
    check("full_set", full_a, 1);
    tick(); check("alloc5_noack", ack_a, 0); check("alloc5_active", active_a, 4'b1111);
    fire_a = 1'b0;
    hit_a = 4'b0100;
    tick();
    hit_a = 4'b0000;
    check("free2", active_a, 4'b1011);
    check("full_clr", full_a, 0);
    fire_a = 1'b1; ox_a = 10'd1020; oy_a = 10'd123;
    tick();
    fire_a = 1'b0;
    check("refill2", active_a, 4'b1111);
    check("refill2_y", py_a[29:20], 123);
    check("refill2_xwrap", px_a[29:20], 10);

    // fire+frame and hit+frame
    hit_a = 4'b1111;
    tick();
    hit_a = 4'b0000;
    check("clear_all", active_a, 0);
    fire_a = 1'b1; oy_a = 10'd200;
    tick();
    oy_a = 10'd250; frame_a = 1'b1;
    tick();
    fire_a = 1'b0;
    check("ff_active", active_a, 4'b0011);
    check("ff_slot0", py_a[9:0], 196);
    check("ff_slot1", py_a[19:10], 250);
    hit_a = 4'b0001;
    tick();
    hit_a = 4'b0000; frame_a = 1'b0;
    check("hf_active", active_a, 4'b0010);
    check("hf_slot0_hold", py_a[9:0], 196);
    check("hf_slot1", py_a[19:10], 246);
    hit_a = 4'b0100;
    tick();
    hit_a = 4'b0000;
    check("hit_idle_ignored", active_a, 4'b0010);

    // Cooldown
    fire_b = 1'b1; oy_b = 10'd400;
    tick();
    check("cd_first_ack", ack_b, 1);
    for (int k = 1; k <= 8; k++) begin
      frame_b = 1'b1;
      tick();
      check($sformatf("cd_frame%0d", k), ack_b, 0);
      frame_b = 1'b0;
      if (k < 8) begin
        tick();
        check($sformatf("cd_gap%0d", k), ack_b, 0);
      end
    end
    tick();
    fire_b = 1'b0;
    check("cd_release_ack", ack_b, 1);
    check("cd_release_active", active_b, 4'b0011);

    // Downward travel and exit
    fire_c = 1'b1; oy_c = 10'd464;
    tick();
    fire_c = 1'b0;
    check("dn_spawn", py_c[9:0], 464);
    frame_c = 1'b1;
    tick();
    check("dn_y468", py_c[9:0], 468);
    check("dn_live", active_c, 4'b0001);
    tick();
    frame_c = 1'b0;
    check("dn_exit", active_c, 4'b0000);
    check("dn_hold", py_c[9:0], 468);

    // Asynchronous reset mid-flight
    fire_c = 1'b1; oy_c = 10'd100;
    tick();
    fire_c = 1'b0;
    check("dn_respawn", active_c, 4'b0001);
    #2 rst_n_c = 1'b0;
    #1;
    check("async_rst_active", active_c, 0);
    check("async_rst_py", py_c[9:0], 0);
    tick();
    rst_n_c = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
